// File: rtl/irq_controller_if.sv
// CPU bus bundle for the interrupt controller: chip select, read/write,
// register address, write data and combinational read data.
interface irq_controller_if;
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output cs, rw, addr, data_in, input data_out);
    modport slave  (input cs, rw, addr, data_in, output data_out);
endinterface

// File: rtl/irq_controller.sv
// Programmable interrupt controller: synchronizes NUM_SRC sources, applies
// polarity and edge/level detection, latches pending bits and drives irq_n.
module irq_controller #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_controller_if.slave      bus,
    input  logic [NUM_SRC-1:0]   irq_src,
    output logic                 irq_n
);

    // Register bits at and above NUM_SRC are forced to zero everywhere.
    localparam logic [7:0] VALID = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] hist_q, hist_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] edge_q, edge_d;
    logic [7:0] pol_q, pol_d;
    logic [7:0] pend_q, pend_d;
    logic       irq_n_q, irq_n_d;

    logic [7:0] src_ext;
    logic [7:0] act;
    logic [7:0] clr;
    logic [7:0] active;
    logic [7:0] vector;
    logic       wr;
    logic       found;

    always_comb begin
        src_ext                = '0;
        src_ext[NUM_SRC-1:0]   = irq_src;
        wr                     = bus.cs && !bus.rw;
        act                    = (s2_q ^ pol_q) & VALID;
        clr                    = (wr && bus.addr == 3'd0) ? bus.data_in : '0;

        s1_d   = src_ext & VALID;
        s2_d   = s1_q;
        hist_d = act;

        // Edge bits: set beats clear; level bits follow act and ignore W1C.
        pend_d = ((edge_q & ((pend_q & ~clr) | (act & ~hist_q))) |
                  (~edge_q & act)) & VALID;

        mask_d = (wr && bus.addr == 3'd1) ? (bus.data_in & VALID) : mask_q;
        edge_d = (wr && bus.addr == 3'd2) ? (bus.data_in & VALID) : edge_q;
        pol_d  = (wr && bus.addr == 3'd3) ? (bus.data_in & VALID) : pol_q;

        active  = pend_q & mask_q;
        irq_n_d = ~|active;
    end

    always_comb begin
        vector = 8'h80;
        found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (active[i] && !found) begin
                vector = {5'b0, 3'(i)};
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.data_out = '0;
        unique case (bus.addr)
            3'd0:    bus.data_out = pend_q;
            3'd1:    bus.data_out = mask_q;
            3'd2:    bus.data_out = edge_q;
            3'd3:    bus.data_out = pol_q;
            3'd4:    bus.data_out = vector;
            3'd5:    bus.data_out = act;
            default: bus.data_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            hist_q  <= '0;
            mask_q  <= '0;
            edge_q  <= VALID;
            pol_q   <= '0;
            pend_q  <= '0;
            irq_n_q <= 1'b1;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            hist_q  <= hist_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pol_q   <= pol_d;
            pend_q  <= pend_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table plus hand-written
// latency, priority, polarity, set/clear race and async reset sequences.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = '0;
    logic       irq_n;

    irq_controller_if bus_if ();

    irq_controller #(.NUM_SRC(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .irq_src (irq_src),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        logic       do_wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_if.cs      = 1'b1;
        bus_if.rw      = 1'b0;
        bus_if.addr    = a;
        bus_if.data_in = d;
        tick(1);
        bus_if.cs      = 1'b0;
        bus_if.rw      = 1'b1;
    endtask

    // Combinational read mid-cycle; does not consume a clock edge.
    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        sb_t e;
        bus_if.cs   = 1'b1;
        bus_if.rw   = 1'b1;
        bus_if.addr = a;
        exp_q.push_back('{name, exp});
        #2;
        e = exp_q.pop_front();
        check(e.name, bus_if.data_out, e.exp);
        bus_if.cs = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string name);
        check(name, {7'b0, irq_n}, {7'b0, exp});
    endtask

    initial begin
        bus_if.cs = 1'b0; bus_if.rw = 1'b1; bus_if.addr = '0; bus_if.data_in = '0;

        tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, "rst_pend"};
        tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, "rst_mask"};
        tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'hFF, "rst_edge"};
        tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, "rst_pol"};
        tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h80, "rst_vector"};
        tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00, "rst_raw"};
        tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00, "rst_reg6"};
        tbl[7]  = '{1'b0, 3'd7, 8'h00, 8'h00, "rst_reg7"};
        tbl[8]  = '{1'b1, 3'd1, 8'h5A, 8'h5A, "mask_rw_5a"};
        tbl[9]  = '{1'b1, 3'd1, 8'h00, 8'h00, "mask_rw_00"};
        tbl[10] = '{1'b1, 3'd4, 8'h33, 8'h80, "vector_ro"};
        tbl[11] = '{1'b1, 3'd6, 8'h77, 8'h00, "reg6_wr_ignored"};
        tbl[12] = '{1'b1, 3'd3, 8'h00, 8'h00, "pol_rw_00"};
        tbl[13] = '{1'b1, 3'd0, 8'hFF, 8'h00, "pend_w1c_empty"};

        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk_irq(1'b1, "rst_irq_n");
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end

        // Latency and W1C on edge-mode source 1.
        wr(3'd1, 8'h03);
        irq_src[1] = 1'b1;
        tick(2);
        rd(3'd0, 8'h00, "lat_pend_k1");
        tick(1);
        irq_src[1] = 1'b0;
        rd(3'd0, 8'h02, "lat_pend_k2");
        chk_irq(1'b1, "lat_irq_k2");
        tick(1);
        chk_irq(1'b0, "lat_irq_k3");
        rd(3'd4, 8'h01, "lat_vector");
        tick(2);
        rd(3'd0, 8'h02, "edge_hold");
        wr(3'd0, 8'h02);
        rd(3'd0, 8'h00, "w1c_pend");
        chk_irq(1'b0, "w1c_irq_lag");
        tick(1);
        chk_irq(1'b1, "w1c_irq_high");

        // Priority between sources 1 and 5.
        irq_src[1] = 1'b1; irq_src[5] = 1'b1;
        tick(3);
        irq_src[1] = 1'b0; irq_src[5] = 1'b0;
        wr(3'd1, 8'h22);
        rd(3'd0, 8'h22, "prio_pend");
        rd(3'd4, 8'h01, "prio_vec_1");
        wr(3'd0, 8'h02);
        rd(3'd4, 8'h05, "prio_vec_5");
        wr(3'd0, 8'h20);
        rd(3'd4, 8'h80, "prio_vec_none");

        // Level mode, active-low source 0.
        wr(3'd2, 8'hFE);
        wr(3'd3, 8'h01);
        tick(2);
        rd(3'd0, 8'h01, "lvl_pend");
        rd(3'd5, 8'h01, "lvl_raw");
        wr(3'd0, 8'h01);
        rd(3'd0, 8'h01, "lvl_w1c_noeffect");
        irq_src[0] = 1'b1;
        tick(2);
        rd(3'd0, 8'h01, "lvl_release_k1");
        tick(1);
        rd(3'd0, 8'h00, "lvl_release_k2");
        wr(3'd2, 8'hFF);

        // Edge on source 2 in the same cycle as its W1C: set wins.
        irq_src[2] = 1'b1;
        tick(2);
        wr(3'd0, 8'h04);
        rd(3'd0, 8'h04, "set_beats_clr");
        irq_src[2] = 1'b0;
        wr(3'd0, 8'h04);
        rd(3'd0, 8'h00, "clr_after_race");

        // Masked pending source 3, then unmask.
        wr(3'd1, 8'h00);
        irq_src[3] = 1'b1;
        tick(3);
        irq_src[3] = 1'b0;
        rd(3'd0, 8'h08, "masked_pend");
        tick(1);
        chk_irq(1'b1, "masked_irq_high");
        wr(3'd1, 8'h08);
        chk_irq(1'b1, "unmask_irq_k");
        tick(1);
        chk_irq(1'b0, "unmask_irq_k1");
        rd(3'd4, 8'h03, "unmask_vector");

        // Asynchronous reset between clock edges.
        #1;
        rst_n = 1'b0;
        #1;
        chk_irq(1'b1, "async_rst_irq");
        rd(3'd0, 8'h00, "async_rst_pend");
        rd(3'd1, 8'h00, "async_rst_mask");
        rd(3'd3, 8'h00, "async_rst_pol");
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk_irq(1'b1, "post_rst_irq");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
